// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the write-back stage.
//   word_t    : default-width datapath word
//   wsel_t    : write-data source select (ALU, MEM, NPC, IMM)
//   ldtype_t  : load extraction kind; encodings 5-7 are treated as a full word
package cpu_types_pkg;

  localparam int WORD_W_DEFAULT = 32;

  typedef logic [WORD_W_DEFAULT-1:0] word_t;

  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_MEM = 2'd1,
    WSEL_NPC = 2'd2,
    WSEL_IMM = 2'd3
  } wsel_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ldtype_t;

endpackage

// File: rtl/stage_wb_pipe_if.sv
// Upstream (MEM stage -> WB stage) entry channel.
//   in_valid / in_ready : valid-ready handshake, entry moves when both are 1
//   in_regWrite, in_regSel, in_wsel, in_ldType, in_addrLo, in_halt : control
//   in_aluOut, in_dmemload, in_npc, in_imm : candidate write data
// master = producer (MEM stage), slave = consumer (stage_wb_pipe).
interface stage_wb_pipe_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
);

  logic              in_valid;
  logic              in_ready;
  logic              in_regWrite;
  logic [REG_AW-1:0] in_regSel;
  logic [1:0]        in_wsel;
  logic [2:0]        in_ldType;
  logic [1:0]        in_addrLo;
  logic              in_halt;
  logic [WORD_W-1:0] in_aluOut;
  logic [WORD_W-1:0] in_dmemload;
  logic [WORD_W-1:0] in_npc;
  logic [WORD_W-1:0] in_imm;

  modport master (
    output in_valid, in_regWrite, in_regSel, in_wsel, in_ldType, in_addrLo,
           in_halt, in_aluOut, in_dmemload, in_npc, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_regWrite, in_regSel, in_wsel, in_ldType, in_addrLo,
           in_halt, in_aluOut, in_dmemload, in_npc, in_imm,
    output in_ready
  );

endinterface

// File: rtl/load_extract.sv
// Combinational little-endian load extraction.
//   data    : loaded memory word
//   ld_type : ldtype_t encoding (W, B, BU, H, HU); 5-7 behave as W
//   addr_lo : byte offset within the word; halfwords use addr_lo[1] only
//   result  : extracted, sign- or zero-extended value
module load_extract
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  output logic [WORD_W-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every variable written here gets a value before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_b = data[{addr_lo, 3'b000} +: 8];
    lane_h = data[{addr_lo[1], 4'b0000} +: 16];
    result = data;
    case (ld_type)
      LD_B:    result = {{(WORD_W-8){lane_b[7]}}, lane_b};
      LD_BU:   result = {{(WORD_W-8){1'b0}}, lane_b};
      LD_H:    result = {{(WORD_W-16){lane_h[15]}}, lane_h};
      LD_HU:   result = {{(WORD_W-16){1'b0}}, lane_h};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/stage_wb_pipe.sv
// Write-back stage: output register plus one skid entry feeding the register
// file write port, with bypass reporting, sticky halt and a retire counter.
//   CLK, nRST      : clock, asynchronous active-low reset
//   up             : upstream entry channel (slave side)
//   rf_ready       : register-file write port free this cycle
//   rf_wen/wsel/wdat : register-file write request from the output register
//   fwd_valid/sel/dat : youngest pending write (skid if valid, else output)
//   halt           : set the cycle after a halt entry retires, sticky
//   retire_cnt     : number of cycles with rf_wen=1, wrapping
module stage_wb_pipe
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  stage_wb_pipe_if.slave    up,
  input  logic              rf_ready,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_wsel,
  output logic [WORD_W-1:0] rf_wdat,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_sel,
  output logic [WORD_W-1:0] fwd_dat,
  output logic              halt,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] reg_sel;
    logic [WORD_W-1:0] wdat;
    logic              halt;
  } entry_t;

  entry_t            in_e;
  entry_t            out_q;
  entry_t            skid_q;
  logic              out_valid;
  logic              skid_valid;
  logic              halt_pending;
  logic              halt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] mem_data;
  logic              accept;
  logic              retire;
  logic              out_free;

  load_extract #(.WORD_W(WORD_W)) u_load_extract (
    .data    (up.in_dmemload),
    .ld_type (up.in_ldType),
    .addr_lo (up.in_addrLo),
    .result  (mem_data)
  );

  // Write data is resolved at acceptance, so stored entries carry only the
  // final value and the upstream fields need not be held.
  always_comb begin
    in_e           = '0;
    in_e.reg_write = up.in_regWrite;
    in_e.reg_sel   = up.in_regSel;
    in_e.halt      = up.in_halt;
    case (up.in_wsel)
      WSEL_ALU: in_e.wdat = up.in_aluOut;
      WSEL_MEM: in_e.wdat = mem_data;
      WSEL_NPC: in_e.wdat = up.in_npc;
      WSEL_IMM: in_e.wdat = up.in_imm;
    endcase
  end

  // Ready depends on registered state only; rf_ready never reaches in_ready.
  assign up.in_ready = !skid_valid && !halt_q && !halt_pending;
  assign accept      = up.in_valid && up.in_ready;
  assign retire      = out_valid && rf_ready;
  assign out_free    = !out_valid || retire;

  // NOTE: stored fields are reset along with the valid bits so that every
  // observable output (including rf_wsel/rf_wdat/fwd_*) is 0 during reset;
  // this is a few flops, not a memory array.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid    <= 1'b0;
      skid_valid   <= 1'b0;
      halt_pending <= 1'b0;
      halt_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge state, e.g. out_q takes the old skid_q while skid_q reloads.
      if (out_free) begin
        if (skid_valid) begin
          out_q      <= skid_q;
          out_valid  <= 1'b1;
          skid_valid <= accept;
          if (accept) skid_q <= in_e;
        end else begin
          out_valid <= accept;
          if (accept) out_q <= in_e;
        end
      end else if (accept) begin
        skid_q     <= in_e;
        skid_valid <= 1'b1;
      end

      if (accept && up.in_halt) halt_pending <= 1'b1;
      if (retire && out_q.halt) halt_q       <= 1'b1;
      if (rf_wen)               cnt_q        <= cnt_q + CNT_W'(1);
    end
  end

  assign rf_wen  = out_valid && out_q.reg_write && (out_q.reg_sel != '0) && rf_ready;
  assign rf_wsel = out_q.reg_sel;
  assign rf_wdat = out_q.wdat;

  // The skid entry is always younger than the output entry.
  assign fwd_sel   = skid_valid ? skid_q.reg_sel : out_q.reg_sel;
  assign fwd_dat   = skid_valid ? skid_q.wdat    : out_q.wdat;
  assign fwd_valid = skid_valid ? (skid_q.reg_write && (skid_q.reg_sel != '0))
                                : (out_valid && out_q.reg_write && (out_q.reg_sel != '0));

  assign halt       = halt_q;
  assign retire_cnt = cnt_q;

endmodule
